// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Request/response handshake and data-memory bus of the load/store unit.
//
//   req_valid/req_ready       request handshake (transfer on valid && ready)
//   req_write/req_size/...    request fields (store flag, size, zero-extend,
//                             byte address, right-aligned store data)
//   resp_valid/rdata/error    one-cycle response pulse
//   mem_address/...           word-addressed memory with 1-cycle registered read
//
// Modports: slave  = load_store_unit side
//           master = CPU datapath + memory side
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Byte/half/word loads and stores between the CPU datapath and a word-addressed
// 32-bit data memory (registered read, 1-cycle latency, word writes only).
// Sub-word stores are read-modify-write. Misaligned, illegal-size and
// out-of-range requests answer with an error pulse and never touch memory.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        load_store_unit_if.slave (request, response, memory bus)
//   load_count/store_count/error_count  (only with LSU_PERF_CNT_EN)
//                                       saturating 16-bit response counters
//
// Parameter:
//   MEM_INDEX_BITS  word-index bits decoded by the memory
//
// Optional feature macro: LSU_PERF_CNT_EN
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_INDEX_BITS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0]        load_count,
    output logic [15:0]        store_count,
    output logic [15:0]        error_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [29:0] r_word_idx;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_error;

    logic [29:0] w_idx;
    logic        w_oob;
    logic        w_misaligned;
    logic        w_error;
    logic        w_accept;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_lane_mask;
    logic [31:0] w_merged;
    logic        w_pulse_load;
    logic        w_pulse_store;
    logic        w_pulse_error;

    // Request decode at accept
    assign w_idx        = bus.req_addr[31:2];
    assign w_oob        = (w_idx >> MEM_INDEX_BITS) != '0;
    assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_error      = (bus.req_size == 2'b11) || w_misaligned || w_oob;
    assign w_accept     = bus.req_valid && (r_state == S_IDLE);

    // Lane handling for the latched request; half accesses are aligned so
    // r_lane[0] is 0 and the same byte shift serves both sizes.
    assign w_shamt   = {r_lane, 3'b000};
    assign w_shifted = bus.mem_read_data >> w_shamt;

    always_comb begin
        w_load_data = bus.mem_read_data;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h000000, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'h0000, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = bus.mem_read_data;
        endcase
    end

    assign w_lane_mask = (r_size == 2'b00) ? (32'h0000_00FF << w_shamt)
                                           : (32'h0000_FFFF << w_shamt);
    assign w_merged    = (bus.mem_read_data & ~w_lane_mask) |
                         ((r_wdata << w_shamt) & w_lane_mask);

    assign w_pulse_error = w_accept && w_error;
    assign w_pulse_load  = (r_state == S_CAP) && !r_write;
    assign w_pulse_store = ((r_state == S_CAP) && r_write) || (r_state == S_WR);

    // Write strobe/data decode from state so an asynchronous reset drops the
    // strobe at once; write data is combinational because the RMW merge needs
    // mem_read_data, which is only valid during CAP.
    assign bus.mem_write_enable = (r_state == S_WR) || ((r_state == S_CAP) && r_write);

    always_comb begin
        bus.mem_write_data = '0;
        if (r_state == S_WR) begin
            bus.mem_write_data = r_wdata;
        end else if ((r_state == S_CAP) && r_write) begin
            bus.mem_write_data = w_merged;
        end
    end

    assign bus.mem_address = {2'b00, r_word_idx};
    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_error  = r_resp_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_lane       <= '0;
            r_word_idx   <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_error) begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_write    <= bus.req_write;
                            r_size     <= bus.req_size;
                            r_unsigned <= bus.req_unsigned;
                            r_lane     <= bus.req_addr[1:0];
                            r_word_idx <= w_idx;
                            r_wdata    <= bus.req_wdata;
                            r_state    <= (bus.req_write && (bus.req_size == 2'b10)) ? S_WR : S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_write ? '0 : w_load_data;
                end
                S_WR: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    // Counters step together with the response pulse they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_count  <= '0;
            store_count <= '0;
            error_count <= '0;
        end else begin
            if (w_pulse_load && (load_count != 16'hFFFF)) begin
                load_count <= load_count + 16'd1;
            end
            if (w_pulse_store && (store_count != 16'hFFFF)) begin
                store_count <= store_count + 16'd1;
            end
            if (w_pulse_error && (error_count != 16'hFFFF)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests checked against a byte-level reference memory model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clock;
    logic reset_n;

    load_store_unit_if bus ();

    load_store_unit #(
        .MEM_INDEX_BITS(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total;
    int bad;

    // Data memory: 16 words, registered read, plus a backdoor preload port.
    logic [31:0] tb_mem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clock) begin
        if (pl_en) begin
            tb_mem[pl_idx] <= pl_data;
        end else if (bus.mem_write_enable && (bus.mem_address < 32'd16)) begin
            tb_mem[bus.mem_address[3:0]] <= bus.mem_write_data;
        end
        bus.mem_read_data <= tb_mem[bus.mem_address[3:0]];
    end

    // Reference memory, updated by the model only.
    logic [31:0] ref_mem [16];

    task automatic preload(input int unsigned idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx[3:0];
        pl_data = data;
        ref_mem[idx] = data;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Reference model at the byte level: returns expected data, error and
    // response latency (cycles after the accept edge).
    task automatic model(input bit w, input bit [1:0] sz, input bit u,
                         input bit [31:0] a, input bit [31:0] wd,
                         output bit [31:0] er, output bit ee, output int el);
        int unsigned n;
        int unsigned idx;
        int unsigned off;
        bit [63:0]   v;
        er = '0;
        n  = 32'd1 << sz;
        ee = (sz == 2'b11) || ((a % n) != 0) || ((a / 4) >= 16);
        el = 1;
        if (ee) return;
        idx = a / 4;
        off = a % 4;
        if (w) begin
            for (int unsigned i = 0; i < n; i++) begin
                ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
            end
            el = (n == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) begin
                v = v | (64'(ref_mem[idx][8*(off+i) +: 8]) << (8*i));
            end
            if (!u && v[8*n-1]) v = v - (64'd1 << (8*n));
            er = v[31:0];
            el = 3;
        end
    endtask

    // Drive one request (called just after a clock edge with the unit idle)
    // and record what the unit did. lat = -1 when no response within budget.
    task automatic do_req(input bit w, input bit [1:0] sz, input bit u,
                          input bit [31:0] a, input bit [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output bit we_seen,
                          output logic valid_after);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        lat     = -1;
        we_seen = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.mem_write_enable) we_seen = 1'b1;
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                err   = bus.resp_error;
                break;
            end
            @(posedge clock); #1;
        end
        valid_after = 1'b0;
        if (lat > 0) begin
            @(posedge clock); #1;
            valid_after = bus.resp_valid;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=0", bus.resp_rdata); end
        total++; if (bus.resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp_error got=%b want=0", bus.resp_error); end
        total++; if (bus.mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.mem_write_enable); end
        total++; if (bus.mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.mem_write_data); end
        total++; if (bus.mem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.mem_address); end
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_word_load();
        logic [31:0] rd; logic er; int lat; bit we; logic va;
        bit [31:0] mr; bit me; int ml;
        model(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, mr, me, ml);
        do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat, we, va);
        total++; if (rd !== 32'h00010100) begin bad++; $display("FAIL lw_data got=%h want=00010100", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err got=%b want=0", er); end
        total++; if (lat != 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", lat); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b want=0", we); end
        total++; if (va !== 1'b0) begin bad++; $display("FAIL lw_pulse_width got=%b want=0", va); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat; bit we; logic va;
        bit [31:0] mr; bit me; int ml;
        model(1'b1, 2'b00, 1'b0, 32'h0A, 32'h80, mr, me, ml);
        do_req(1'b1, 2'b00, 1'b0, 32'h0A, 32'h80, rd, er, lat, we, va);
        total++; if (tb_mem[2] !== 32'h00800001) begin bad++; $display("FAIL sb_mem got=%h want=00800001", tb_mem[2]); end
        total++; if (lat != 3 || rd !== 32'h0 || we !== 1'b1) begin bad++; $display("FAIL sb_resp got lat=%0d rd=%h we=%b want lat=3 rd=0 we=1", lat, rd, we); end
        model(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, mr, me, ml);
        do_req(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, rd, er, lat, we, va);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", rd); end
        model(1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, mr, me, ml);
        do_req(1'b0, 2'b00, 1'b1, 32'h0A, 32'h0, rd, er, lat, we, va);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h want=00000080", rd); end
        model(1'b1, 2'b01, 1'b0, 32'h0E, 32'hBEEF, mr, me, ml);
        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hBEEF, rd, er, lat, we, va);
        total++; if (tb_mem[3] !== 32'hBEEF1000) begin bad++; $display("FAIL sh_mem got=%h want=beef1000", tb_mem[3]); end
        model(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, mr, me, ml);
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er, lat, we, va);
        total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_data got=%h want=ffffbeef", rd); end
        model(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, mr, me, ml);
        do_req(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, rd, er, lat, we, va);
        total++; if (rd !== 32'h00001000) begin bad++; $display("FAIL lhu_data got=%h want=00001000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit we; logic va;
        logic [31:0] w0;
        bit [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        bit [31:0] ad [4] = '{32'h06, 32'h01, 32'h00, 32'h40};
        bit        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        w0 = tb_mem[0];
        for (int i = 0; i < 4; i++) begin
            do_req(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, rd, er, lat, we, va);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || we !== 1'b0) begin
                bad++;
                $display("FAIL err_case%0d got err=%b rd=%h lat=%0d we=%b want err=1 rd=0 lat=1 we=0", i, er, rd, lat, we);
            end
        end
        total++; if (tb_mem[0] !== w0) begin bad++; $display("FAIL err_no_write got=%h want=%h", tb_mem[0], w0); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] w2;
        bit          saw_resp;
        w2 = tb_mem[2];
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h08;
        bus.req_wdata    = 32'h55;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(posedge clock); #1;
        total++; if (bus.mem_write_enable !== 1'b1) begin bad++; $display("FAIL rst_cap_we got=%b want=1", bus.mem_write_enable); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.mem_write_enable !== 1'b0) begin bad++; $display("FAIL rst_we_drop got=%b want=0", bus.mem_write_enable); end
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) saw_resp = 1'b1;
            @(posedge clock); #1;
        end
        total++; if (saw_resp) begin bad++; $display("FAIL rst_no_resp got=1 want=0"); end
        total++; if (tb_mem[2] !== w2) begin bad++; $display("FAIL rst_no_write got=%h want=%h", tb_mem[2], w2); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_back_to_back();
        bit [31:0] mr; bit me; int ml;
        int lat;
        model(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, mr, me, ml);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_wdata    = 32'h12345678;
        @(posedge clock); #1;
        // Next request presented while the store is in flight; valid stays high.
        bus.req_write = 1'b0;
        bus.req_wdata = 32'h0;
        @(posedge clock); #1;
        total++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_sw_resp got valid=%b ready=%b want 1 1", bus.resp_valid, bus.req_ready); end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_single_pulse got=%b want=0", bus.resp_valid); end
        model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mr, me, ml);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            if (bus.resp_valid) begin lat = c; break; end
            @(posedge clock); #1;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL b2b_lw_latency got=%0d want=3", lat); end
        total++; if (bus.resp_rdata !== mr || mr != 32'h12345678) begin bad++; $display("FAIL b2b_lw_data got=%h want=12345678", bus.resp_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; bit we; logic va;
        bit [31:0] mr; bit me; int ml;
        bit w; bit [1:0] sz; bit u; bit [31:0] a; bit [31:0] wd;
        int unsigned idx;
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 32'h47);
            if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            model(w, sz, u, a, wd, mr, me, ml);
            do_req(w, sz, u, a, wd, rd, er, lat, we, va);
            total++;
            if (rd !== mr || er !== me || lat != ml || we !== (w && !me) || va !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d w=%b sz=%0d a=%h got rd=%h err=%b lat=%0d we=%b want rd=%h err=%b lat=%0d we=%b",
                         i, w, sz, a, rd, er, lat, we, mr, me, ml, (w && !me));
            end
            if (w && !me) begin
                idx = a / 4;
                total++;
                if (tb_mem[idx] !== ref_mem[idx]) begin
                    bad++;
                    $display("FAIL rand%0d_mem idx=%0d got=%h want=%h", i, idx, tb_mem[idx], ref_mem[idx]);
                end
            end
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        pl_en            = 1'b0;
        pl_idx           = '0;
        pl_data          = '0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        test_reset();
        for (int unsigned i = 0; i < 16; i++) preload(i, $urandom);
        preload(1, 32'h00010100);
        preload(2, 32'h00000001);
        preload(3, 32'h00011000);
        test_word_load();
        test_subword();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
